lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_ctrl_if.sv | 47 ++++
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared type codes, FSM states and decode helpers for lsu_ctrl.
// Optional misaligned-access trapping is selected with LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    typedef enum logic [2:0] {
        T_B   = 3'd0,
        T_H   = 3'd1,
        T_W   = 3'd2,
        T_D   = 3'd3,
        T_BU  = 3'd4,
        T_HU  = 3'd5,
        T_WU  = 3'd6,
        T_BAD = 3'd7
    } lsu_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    function automatic logic [1:0] size_log2(input logic [2:0] t);
        return t[1:0];
    endfunction

    // narrow: bus is 32 bits, so doubleword accesses cannot be served
    function automatic logic type_ok(
        input logic [2:0] t,
        input logic       wr,
        input logic       narrow
    );
        logic ok;
        ok = 1'b1;
        if (t == T_BAD)
            ok = 1'b0;
        if (wr && t[2])
            ok = 1'b0;
        if (narrow && (t[1:0] == 2'd3))
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: pipeline request/response and memory bus of the LSU.
// slave is the LSU side; master is the core plus memory environment.
interface lsu_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_write;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_wdata;
    logic [DATA_W/8-1:0] mem_req_wstrb;

    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_resp_err;

    modport slave (
        input  req_valid, req_write, req_type, req_addr, req_wdata,
        input  resp_ready, mem_req_ready,
        input  mem_resp_valid, mem_resp_rdata, mem_resp_err,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req_valid, mem_req_write, mem_req_addr,
        output mem_req_wdata, mem_req_wstrb
    );

    modport master (
        output req_valid, req_write, req_type, req_addr, req_wdata,
        output resp_ready, mem_req_ready,
        output mem_resp_valid, mem_resp_rdata, mem_resp_err,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req_valid, mem_req_write, mem_req_addr,
        input  mem_req_wdata, mem_req_wstrb
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane strobe, store data shift and load extract/extend.
// Purely combinational; lanes past the end of the word are dropped.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int NB     = DATA_W / 8,
    localparam int OW     = $clog2(NB)
) (
    input  logic [2:0]        typ,
    input  logic [OW-1:0]     off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [NB-1:0]     wstrb,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0] rdata_ext
);
    int                nb;
    int                msb;
    logic [NB-1:0]     base;
    logic [DATA_W-1:0] sh;
    logic              sgn;

    always_comb begin
        unique case (size_log2(typ))
            2'd0:    nb = 1;
            2'd1:    nb = 2;
            2'd2:    nb = 4;
            default: nb = 8;
        endcase
        base = '0;
        for (int i = 0; i < NB; i++)
            base[i] = (i < nb);
        wstrb    = base << off;
        wdata_sh = wdata << {off, 3'b000};
        sh       = rdata >> {off, 3'b000};
        msb = (8 * nb > DATA_W) ? DATA_W - 1 : 8 * nb - 1;
        sgn = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (i == msb)
                sgn = sh[i] & ~typ[2];
        rdata_ext = '0;
        for (int i = 0; i < DATA_W; i++)
            rdata_ext[i] = (i <= msb) ? sh[i] : sgn;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller, IDLE-REQ-WAIT-RESP.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses without memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int ADDR_W = 64,
    localparam int NB     = DATA_W / 8,
    localparam int OW     = $clog2(NB)
) (
    input logic       clock,
    input logic       reset_n,
    lsu_ctrl_if.slave bus
);
    lsu_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        typ_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mreq_q;
    logic              resp_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              bad;
    logic              mis;
    logic [DATA_W-1:0] ext;

    assign bad = ~type_ok(bus.req_type, bus.req_write, DATA_W == 32);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        unique case (size_log2(bus.req_type))
            2'd0:    mis = 1'b0;
            2'd1:    mis = bus.req_addr[0];
            2'd2:    mis = |bus.req_addr[1:0];
            default: mis = |bus.req_addr[2:0];
        endcase
    end
`else
    assign mis = 1'b0;
`endif

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .typ       (typ_q),
        .off       (addr_q[OW-1:0]),
        .wdata     (wdata_q),
        .rdata     (bus.mem_resp_rdata),
        .wstrb     (bus.mem_req_wstrb),
        .wdata_sh  (bus.mem_req_wdata),
        .rdata_ext (ext)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            typ_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            mreq_q  <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    addr_q  <= bus.req_addr;
                    typ_q   <= bus.req_type;
                    wr_q    <= bus.req_write;
                    wdata_q <= bus.req_wdata;
                    // faulting requests skip memory entirely
                    if (bad || mis) begin
                        state   <= S_RESP;
                        resp_q  <= 1'b1;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        state  <= S_REQ;
                        mreq_q <= 1'b1;
                    end
                end
                S_REQ: if (bus.mem_req_ready) begin
                    state  <= S_WAIT;
                    mreq_q <= 1'b0;
                end
                S_WAIT: if (bus.mem_resp_valid) begin
                    state   <= S_RESP;
                    resp_q  <= 1'b1;
                    err_q   <= bus.mem_resp_err;
                    rdata_q <= (wr_q || bus.mem_resp_err) ? '0 : ext;
                end
                S_RESP: if (bus.resp_ready) begin
                    state  <= S_IDLE;
                    resp_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (state == S_IDLE);
    assign bus.mem_req_valid = mreq_q;
    assign bus.mem_req_write = wr_q;
    assign bus.mem_req_addr  = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    assign bus.resp_valid    = resp_q;
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_err      = err_q;

endmodule
